// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM output registers and an iterative multiply/divide unit.
// While the MDU iterates, the stage stalls upstream and feeds bubbles into EX/MEM.
module ex_mem_stage #(
    parameter int ENABLE_MDU = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  wb_ctl,
    input  logic [2:0]  m_ctl,
    input  logic        regdst,
    input  logic [1:0]  aluop,
    input  logic        alusrc,
    input  logic [31:0] npc,
    input  logic [31:0] rdata1,
    input  logic [31:0] rdata2,
    input  logic [31:0] add_in2,
    input  logic [5:0]  funct,
    input  logic [4:0]  instr_2016,
    input  logic [4:0]  instr_1511,
    output logic        stall,
    output logic [1:0]  wb_ctlout,
    output logic [2:0]  m_ctlout,
    output logic [31:0] add_result,
    output logic        zero,
    output logic [31:0] alu_result,
    output logic [31:0] rdata2out,
    output logic [4:0]  muxout
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2A;

    logic        mduEn;
    logic [31:0] operandB;
    logic [31:0] aluValue;
    logic        mduOp;
    logic        startMdu;
    logic        bubble;
    logic        doneSlot;
    logic        negA;
    logic        negB;

    logic [1:0]  state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] mdB_q, mdB_d;
    logic [31:0] rsRaw_q, rsRaw_d;
    logic [1:0]  mdOp_q, mdOp_d;
    logic        negA_q, negA_d;
    logic        negB_q, negB_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [1:0]  wbCtl_q, wbCtl_d;
    logic [2:0]  mCtl_q, mCtl_d;
    logic [31:0] addResult_q, addResult_d;
    logic        zero_q, zero_d;
    logic [31:0] aluResult_q, aluResult_d;
    logic [31:0] rdata2Out_q, rdata2Out_d;
    logic [4:0]  mux_q, mux_d;

    logic [32:0] mulSum;
    logic [63:0] mulNext;
    logic [32:0] divShift;
    logic        divFits;
    logic [32:0] divRem;
    logic [63:0] divNext;
    logic [63:0] accStep;
    logic [63:0] prodFinal;
    logic [31:0] quoFinal;
    logic [31:0] remFinal;

    assign mduEn    = (ENABLE_MDU != 0);
    assign operandB = alusrc ? add_in2 : rdata2;
    assign mduOp    = mduEn && (aluop == 2'b10) && (funct[5:2] == 4'b0110);
    assign startMdu = (state_q == IDLE) && mduOp;
    assign bubble   = startMdu || (state_q == BUSY);
    assign doneSlot = (state_q == DONE);
    assign stall    = !reset && bubble;

    // Signed ops (funct[0] == 0) iterate on magnitudes and fix the signs at the end.
    assign negA = !funct[0] && rdata1[31];
    assign negB = !funct[0] && rdata2[31];

    always_comb begin
        aluValue = '0;
        case (aluop)
            2'b00: aluValue = rdata1 + operandB;
            2'b01: aluValue = rdata1 - operandB;
            2'b10: begin
                case (funct)
                    F_ADD:  aluValue = rdata1 + operandB;
                    F_SUB:  aluValue = rdata1 - operandB;
                    F_AND:  aluValue = rdata1 & operandB;
                    F_OR:   aluValue = rdata1 | operandB;
                    F_SLT:  aluValue = {31'b0, $signed(rdata1) < $signed(operandB)};
                    F_MFHI: aluValue = mduEn ? hi_q : 32'd0;
                    F_MFLO: aluValue = mduEn ? lo_q : 32'd0;
                    default: aluValue = '0;
                endcase
            end
            default: aluValue = '0;
        endcase
    end

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mulSum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mdB_q} : 33'd0);
        mulNext  = {mulSum, acc_q[31:1]};
        divShift = acc_q[63:31];
        divFits  = (divShift >= {1'b0, mdB_q});
        divRem   = divFits ? (divShift - {1'b0, mdB_q}) : divShift;
        divNext  = {divRem[31:0], acc_q[30:0], divFits};
        accStep  = mdOp_q[1] ? divNext : mulNext;

        prodFinal = (negA_q ^ negB_q) ? -accStep : accStep;
        quoFinal  = (negA_q ^ negB_q) ? -accStep[31:0] : accStep[31:0];
        remFinal  = negA_q ? -accStep[63:32] : accStep[63:32];
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        mdB_d   = mdB_q;
        rsRaw_d = rsRaw_q;
        mdOp_d  = mdOp_q;
        negA_d  = negA_q;
        negB_d  = negB_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (mduOp) begin
                    state_d = BUSY;
                    count_d = 5'd31;
                    acc_d   = {32'b0, negA ? -rdata1 : rdata1};
                    mdB_d   = negB ? -rdata2 : rdata2;
                    rsRaw_d = rdata1;
                    mdOp_d  = funct[1:0];
                    negA_d  = negA;
                    negB_d  = negB;
                end
            end
            BUSY: begin
                acc_d = accStep;
                if (count_q == 5'd0) begin
                    state_d = DONE;
                    if (!mdOp_q[1]) begin
                        hi_d = prodFinal[63:32];
                        lo_d = prodFinal[31:0];
                    end else if (mdB_q == 32'd0) begin
                        hi_d = rsRaw_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = remFinal;
                        lo_d = quoFinal;
                    end
                end else begin
                    count_d = count_q - 5'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // In DONE the frozen MDU instruction retires with its controls cleared so it writes nothing.
    always_comb begin
        wbCtl_d     = '0;
        mCtl_d      = '0;
        addResult_d = '0;
        zero_d      = 1'b0;
        aluResult_d = '0;
        rdata2Out_d = '0;
        mux_d       = '0;
        if (!bubble) begin
            wbCtl_d     = doneSlot ? 2'b00 : wb_ctl;
            mCtl_d      = doneSlot ? 3'b000 : m_ctl;
            aluResult_d = doneSlot ? 32'd0 : aluValue;
            zero_d      = (aluResult_d == 32'd0);
            addResult_d = npc + (add_in2 << 2);
            rdata2Out_d = rdata2;
            mux_d       = regdst ? instr_1511 : instr_2016;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            mdB_q       <= '0;
            rsRaw_q     <= '0;
            mdOp_q      <= '0;
            negA_q      <= 1'b0;
            negB_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            wbCtl_q     <= '0;
            mCtl_q      <= '0;
            addResult_q <= '0;
            zero_q      <= 1'b0;
            aluResult_q <= '0;
            rdata2Out_q <= '0;
            mux_q       <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            mdB_q       <= mdB_d;
            rsRaw_q     <= rsRaw_d;
            mdOp_q      <= mdOp_d;
            negA_q      <= negA_d;
            negB_q      <= negB_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            wbCtl_q     <= wbCtl_d;
            mCtl_q      <= mCtl_d;
            addResult_q <= addResult_d;
            zero_q      <= zero_d;
            aluResult_q <= aluResult_d;
            rdata2Out_q <= rdata2Out_d;
            mux_q       <= mux_d;
        end
    end

    assign wb_ctlout  = wbCtl_q;
    assign m_ctlout   = mCtl_q;
    assign add_result = addResult_q;
    assign zero       = zero_q;
    assign alu_result = aluResult_q;
    assign rdata2out  = rdata2Out_q;
    assign muxout     = mux_q;

endmodule
